// File: rtl/sr_bank_writer.sv
// Purpose : drives S/R inputs of an external SR flip-flop bank until its q feedback equals a requested word.
// Latency : done pulses in the cycle after edge E0+SETTLE+2 (E0 = transfer edge); each retry adds SETTLE+2 cycles.
// Backpress: req_ready only in IDLE; requests presented while busy are ignored, nothing is queued.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready/req_data   target handshake (transfer on valid & ready)
//   q_fb, qb_fb         q / qb feedback from the SR bank
//   s_out, r_out        registered set / reset excitation to the bank (never both 1 on a bit)
//   done                one-cycle completion pulse
//   err_mismatch        with done: q_fb differed from target after all retries
//   err_illegal         with done: some bit showed q_fb == qb_fb at the final check
//   retry_cnt           retries used by the last operation, cleared on transfer
module sr_bank_writer #(
    parameter int WIDTH     = 8,
    parameter int SETTLE    = 1,
    parameter int MAX_RETRY = 2,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1,
    localparam int CW = $clog2(SETTLE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_data,
    output logic             req_ready,
    input  logic [WIDTH-1:0] q_fb,
    input  logic [WIDTH-1:0] qb_fb,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    output logic             done,
    output logic             err_mismatch,
    output logic             err_illegal,
    output logic [RW-1:0]    retry_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_d, r_d;
    logic             done_d, mm_d, il_d;
    logic [RW-1:0]    rc_d;

    assign req_ready = (state_q == IDLE) & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            target_q     <= '0;
            cnt_q        <= '0;
            s_out        <= '0;
            r_out        <= '0;
            done         <= 1'b0;
            err_mismatch <= 1'b0;
            err_illegal  <= 1'b0;
            retry_cnt    <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            cnt_q        <= cnt_d;
            s_out        <= s_d;
            r_out        <= r_d;
            done         <= done_d;
            err_mismatch <= mm_d;
            err_illegal  <= il_d;
            retry_cnt    <= rc_d;
        end
    end

    // Excitation is only ever t&~q (set) or ~t&q (reset); the two terms are
    // disjoint per bit, so the forbidden 11 code cannot be produced even when
    // the feedback itself is illegal. Every state other than the one-cycle
    // drive pulse falls back to the 00 hold code via the defaults.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        s_d      = '0;
        r_d      = '0;
        done_d   = 1'b0;
        mm_d     = err_mismatch;
        il_d     = err_illegal;
        rc_d     = retry_cnt;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    target_d = req_data;
                    s_d      = req_data & ~q_fb;
                    r_d      = ~req_data & q_fb;
                    rc_d     = '0;
                    mm_d     = 1'b0;
                    il_d     = 1'b0;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                cnt_d   = CW'(SETTLE);
                state_d = WAIT;
            end
            WAIT: begin
                // Counter was loaded with SETTLE, so WAIT lasts exactly SETTLE cycles.
                if (cnt_q <= CW'(1)) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            CHECK: begin
                if ((q_fb == target_q) && (qb_fb == ~target_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    mm_d    = 1'b0;
                    il_d    = 1'b0;
                end else if (retry_cnt < RW'(MAX_RETRY)) begin
                    rc_d    = retry_cnt + RW'(1);
                    s_d     = target_q & ~q_fb;
                    r_d     = ~target_q & q_fb;
                    state_d = DRIVE;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    mm_d    = (q_fb != target_q);
                    il_d    = |(~(q_fb ^ qb_fb));
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sr_bank_writer.sv
// Bench for sr_bank_writer: two instances (SETTLE=1 and SETTLE=3) each driving an ideal SR bank model.
// Expected completion records are queued when a request is issued and compared when done pulses.
// Bank model supports a stuck-at-0 mask and forcing q/qb both high on selected bits.
module tb_sr_bank_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_valid3 = 1'b0;
    logic [3:0] req_data = 4'b0000;

    logic       req_ready, done, err_mismatch, err_illegal;
    logic [3:0] s_out, r_out, q_fb, qb_fb;
    logic [1:0] retry_cnt;

    logic       rdy3, done3, mm3, il3;
    logic [3:0] s3, r3, q3, qb3;
    logic [1:0] rc3;

    logic [3:0] bq  = 4'b1010;
    logic [3:0] bq3 = 4'b1010;
    logic [3:0] stuck0 = 4'b0000;
    logic [3:0] frc    = 4'b0000;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int done_cnt = 0;

    typedef struct {
        int edges;
        bit mm;
        bit il;
        int rc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    sr_bank_writer #(.WIDTH(4), .SETTLE(1), .MAX_RETRY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .q_fb(q_fb), .qb_fb(qb_fb), .s_out(s_out),
        .r_out(r_out), .done(done), .err_mismatch(err_mismatch),
        .err_illegal(err_illegal), .retry_cnt(retry_cnt)
    );

    sr_bank_writer #(.WIDTH(4), .SETTLE(3), .MAX_RETRY(2)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_data(req_data),
        .req_ready(rdy3), .q_fb(q3), .qb_fb(qb3), .s_out(s3),
        .r_out(r3), .done(done3), .err_mismatch(mm3),
        .err_illegal(il3), .retry_cnt(rc3)
    );

    // Ideal SR banks: S sets, R resets, stuck bits read 0, forced bits show q=qb=1.
    always @(posedge clk) begin
        bq  <= ((bq | s_out) & ~r_out) & ~stuck0;
        bq3 <= (bq3 | s3) & ~r3;
    end
    assign q_fb  = bq | frc;
    assign qb_fb = ~bq | frc;
    assign q3    = bq3;
    assign qb3   = ~bq3;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (|(s_out | r_out)) pulses++;
        if (done) done_cnt++;
        if (!rst) begin
            chk("sr_excl", {28'd0, s_out & r_out}, 32'd0);
            chk("sr3_excl", {28'd0, s3 & r3}, 32'd0);
        end
    end

    // Count edges after the transfer edge until done is seen (n=0 is the DRIVE cycle).
    task automatic wait_done(output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (n < 40) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic check_done(input int n, input bit seen, input logic mm, input logic il,
                              input logic [1:0] rc);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("latency", n, e.edges);
        chk("err_mismatch", {31'd0, mm}, {31'd0, e.mm});
        chk("err_illegal", {31'd0, il}, {31'd0, e.il});
        chk("retry_cnt", {30'd0, rc}, e.rc);
    endtask

    task automatic do_op(input logic [3:0] tgt, input logic [3:0] exp_s, input logic [3:0] exp_r,
                         input int edges, input bit mm, input bit il, input int rc,
                         input int exp_pulses);
        int  n;
        bit  seen;
        int  p0;
        exp_t e;
        e.edges = edges; e.mm = mm; e.il = il; e.rc = rc;
        sb.push_back(e);
        @(negedge clk);
        p0 = pulses;
        req_data  = tgt;
        req_valid = 1'b1;
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("drive_s", {28'd0, s_out}, {28'd0, exp_s});
        chk("drive_r", {28'd0, r_out}, {28'd0, exp_r});
        chk("rc_clear", {30'd0, retry_cnt}, 32'd0);
        chk("mm_clear", {31'd0, err_mismatch}, 32'd0);
        wait_done(n, seen);
        check_done(n, seen, err_mismatch, err_illegal, retry_cnt);
        chk("ready_in_done", {31'd0, req_ready}, 32'd1);
        chk("drive_pulses", pulses - p0, exp_pulses);
        @(posedge clk); #1;
        chk("done_single", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int  n;
        bit  seen;
        int  d0;
        exp_t e;

        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_s", {28'd0, s_out}, 32'd0);
        chk("rst_r", {28'd0, r_out}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rc", {30'd0, retry_cnt}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // bank 1010
        do_op(4'b1010, 4'b0000, 4'b0000, 3, 0, 0, 0, 0);
        do_op(4'b0110, 4'b0100, 4'b1000, 3, 0, 0, 0, 1);

        // bank 0110, bit0 stuck at 0
        stuck0 = 4'b0001;
        do_op(4'b0001, 4'b0001, 4'b0110, 9, 1, 0, 2, 3);
        stuck0 = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_mm", {31'd0, err_mismatch}, 32'd1);
        chk("hold_rc", {30'd0, retry_cnt}, 32'd2);

        // bank 0000, bit2 shows q=qb=1
        frc = 4'b0100;
        do_op(4'b0000, 4'b0000, 4'b0100, 9, 1, 1, 2, 3);
        frc = 4'b0000;

        // back-to-back with req_valid held high; bank 0000
        e.edges = 3; e.mm = 0; e.il = 0; e.rc = 0;
        sb.push_back(e);
        sb.push_back(e);
        @(negedge clk);
        req_data  = 4'b0101;
        req_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b1_s", {28'd0, s_out}, 32'h5);
        chk("b2b1_r", {28'd0, r_out}, 32'h0);
        wait_done(n, seen);
        check_done(n, seen, err_mismatch, err_illegal, retry_cnt);
        chk("b2b_ready", {31'd0, req_ready}, 32'd1);
        req_data = 4'b1100;
        @(posedge clk); #1;
        chk("b2b2_s", {28'd0, s_out}, 32'h8);
        chk("b2b2_r", {28'd0, r_out}, 32'h1);
        wait_done(n, seen);
        check_done(n, seen, err_mismatch, err_illegal, retry_cnt);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_idle", {31'd0, req_ready}, 32'd1);

        // reset during WAIT; bank 1100
        @(negedge clk);
        req_data  = 4'b0011;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rw_drive_s", {28'd0, s_out}, 32'h3);
        @(posedge clk); #1;
        chk("rw_busy", {31'd0, req_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rw_s", {28'd0, s_out}, 32'd0);
        chk("rw_r", {28'd0, r_out}, 32'd0);
        chk("rw_done", {31'd0, done}, 32'd0);
        chk("rw_ready", {31'd0, req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt;
        #1;
        chk("rw_ready_rel", {31'd0, req_ready}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("rw_no_done", done_cnt - d0, 32'd0);

        // SETTLE=3 instance, bank 1010
        e.edges = 5; e.mm = 0; e.il = 0; e.rc = 0;
        sb.push_back(e);
        @(negedge clk);
        req_data   = 4'b0110;
        req_valid3 = 1'b1;
        chk("s3_ready", {31'd0, rdy3}, 32'd1);
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        chk("s3_drive_s", {28'd0, s3}, 32'h4);
        chk("s3_drive_r", {28'd0, r3}, 32'h8);
        n = 0;
        seen = 1'b0;
        while (n < 40) begin
            if (done3) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (!done3) chk("s3_hold", {28'd0, s3 | r3}, 32'd0);
        end
        check_done(n, seen, mm3, il3, rc3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
